// File: rtl/decode_stage.sv
// RV32I decode stage: one instruction per handshake, decoded bundle held in a 2-entry skid buffer.
// Optional macro DECODE_RV32M_EN adds decoding of the M-extension multiply/divide group.
module decode_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      funct3,
   output logic [XLEN-1:0] imm,
   output logic [5:0]      alu_ctrl,
   output logic [1:0]      op_a_sel,
   output logic            op_b_sel,
   output logic [1:0]      wb_sel,
   output logic            reg_wen,
   output logic            mem_wen,
   output logic            mem_ren,
   output logic            branch_op,
   output logic            jump,
   output logic            illegal
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [XLEN-1:0] imm;
      logic [5:0]      alu_ctrl;
      logic [1:0]      op_a_sel;
      logic            op_b_sel;
      logic [1:0]      wb_sel;
      logic            reg_wen;
      logic            mem_wen;
      logic            mem_ren;
      logic            branch_op;
      logic            jump;
      logic            illegal;
   } bundle_t;

   logic [6:0]      op_f, f7_f;
   logic [2:0]      f3_f;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            bad;
   bundle_t         dec;

   assign op_f  = in_instr[6:0];
   assign f3_f  = in_instr[14:12];
   assign f7_f  = in_instr[31:25];
   assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      dec        = '0;
      bad        = 1'b0;
      dec.pc     = in_pc;
      dec.opcode = op_f;
      case (op_f)
         OpLui, OpAuipc: begin
            dec.rd       = in_instr[11:7];
            dec.imm      = imm_u;
            dec.op_a_sel = (op_f == OpLui) ? 2'b11 : 2'b01;
            dec.op_b_sel = 1'b1;
            dec.reg_wen  = 1'b1;
         end
         OpJal, OpJalr: begin
            dec.rd       = in_instr[11:7];
            dec.op_a_sel = 2'b10;
            dec.op_b_sel = 1'b1;
            dec.wb_sel   = 2'b10;
            dec.reg_wen  = 1'b1;
            dec.jump     = 1'b1;
            if (op_f == OpJal) begin
               dec.imm      = imm_j;
               dec.alu_ctrl = 6'b011111;
            end else begin
               dec.rs1      = in_instr[19:15];
               dec.funct3   = f3_f;
               dec.imm      = imm_i;
               dec.alu_ctrl = 6'b111111;
               bad          = (f3_f != 3'b000);
            end
         end
         OpBranch: begin
            dec.rs1       = in_instr[19:15];
            dec.rs2       = in_instr[24:20];
            dec.funct3    = f3_f;
            dec.imm       = imm_b;
            dec.alu_ctrl  = {3'b010, f3_f};
            dec.branch_op = 1'b1;
            bad           = (f3_f == 3'b010) || (f3_f == 3'b011);
         end
         OpLoad: begin
            dec.rd       = in_instr[11:7];
            dec.rs1      = in_instr[19:15];
            dec.funct3   = f3_f;
            dec.imm      = imm_i;
            dec.op_b_sel = 1'b1;
            dec.wb_sel   = 2'b01;
            dec.mem_ren  = 1'b1;
            dec.reg_wen  = 1'b1;
            bad          = (f3_f == 3'b011) || (f3_f == 3'b110) || (f3_f == 3'b111);
         end
         OpStore: begin
            dec.rs1      = in_instr[19:15];
            dec.rs2      = in_instr[24:20];
            dec.funct3   = f3_f;
            dec.imm      = imm_s;
            dec.op_b_sel = 1'b1;
            dec.mem_wen  = 1'b1;
            bad          = f3_f[2] || (f3_f == 3'b011);
         end
         OpImm: begin
            dec.rd       = in_instr[11:7];
            dec.rs1      = in_instr[19:15];
            dec.funct3   = f3_f;
            dec.imm      = imm_i;
            dec.op_b_sel = 1'b1;
            dec.reg_wen  = 1'b1;
            dec.alu_ctrl = {3'b000, f3_f};
            // Shift immediates carry funct7 in imm[11:5]; only srai may set bit 30.
            if (f3_f == 3'b001) begin
               bad = (f7_f != 7'b0000000);
            end else if (f3_f == 3'b101) begin
               if (f7_f == 7'b0100000) dec.alu_ctrl = 6'b001101;
               else bad = (f7_f != 7'b0000000);
            end
         end
         OpReg: begin
            dec.rd      = in_instr[11:7];
            dec.rs1     = in_instr[19:15];
            dec.rs2     = in_instr[24:20];
            dec.funct3  = f3_f;
            dec.reg_wen = 1'b1;
            if (f7_f == 7'b0000000) begin
               dec.alu_ctrl = {3'b000, f3_f};
            end else if ((f7_f == 7'b0100000) && ((f3_f == 3'b000) || (f3_f == 3'b101))) begin
               dec.alu_ctrl = {3'b001, f3_f};
`ifdef DECODE_RV32M_EN
            end else if (f7_f == 7'b0000001) begin
               dec.alu_ctrl = {3'b100, f3_f};
`endif
            end else begin
               bad = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase
      if (dec.rd == 5'd0) dec.reg_wen = 1'b0;
      if (bad) begin
         dec.reg_wen   = 1'b0;
         dec.mem_wen   = 1'b0;
         dec.mem_ren   = 1'b0;
         dec.branch_op = 1'b0;
         dec.jump      = 1'b0;
      end
      dec.illegal = bad;
   end

   bundle_t main_q, main_d, skid_q, skid_d;
   logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic    in_ready_q, in_ready_d;
   logic    in_fire, out_fire;

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = main_valid_q && out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_fire) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = in_fire;
            if (in_fire) skid_d = dec;
         end else begin
            main_valid_d = in_fire;
            if (in_fire) main_d = dec;
         end
      end else if (in_fire) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_pc    = main_q.pc;
   assign opcode    = main_q.opcode;
   assign rd        = main_q.rd;
   assign rs1       = main_q.rs1;
   assign rs2       = main_q.rs2;
   assign funct3    = main_q.funct3;
   assign imm       = main_q.imm;
   assign alu_ctrl  = main_q.alu_ctrl;
   assign op_a_sel  = main_q.op_a_sel;
   assign op_b_sel  = main_q.op_b_sel;
   assign wb_sel    = main_q.wb_sel;
   assign reg_wen   = main_q.reg_wen;
   assign mem_wen   = main_q.mem_wen;
   assign mem_ren   = main_q.mem_ren;
   assign branch_op = main_q.branch_op;
   assign jump      = main_q.jump;
   assign illegal   = main_q.illegal;

endmodule
